// File: rtl/spec_free_list.sv
// Speculative physical-register free list: circular buffer with separate
// speculative (rename) and architectural (commit) heads and a shared tail.
module spec_free_list #(
  parameter int PHYS_REGS = 96,
  parameter int LOG_REGS  = 34,
  parameter int PHYS_LOG  = 7,
  parameter int DEPTH     = PHYS_REGS - LOG_REGS
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                allocReq_i,
  input  logic [2:0]          allocCnt_i,
  output logic [PHYS_LOG-1:0] freeReg0_o,
  output logic [PHYS_LOG-1:0] freeReg1_o,
  output logic [PHYS_LOG-1:0] freeReg2_o,
  output logic [PHYS_LOG-1:0] freeReg3_o,
  output logic                stall_o,

  input  logic                releasedValid0_i,
  input  logic                releasedValid1_i,
  input  logic                releasedValid2_i,
  input  logic                releasedValid3_i,
  input  logic [PHYS_LOG-1:0] releasedPhyMap0_i,
  input  logic [PHYS_LOG-1:0] releasedPhyMap1_i,
  input  logic [PHYS_LOG-1:0] releasedPhyMap2_i,
  input  logic [PHYS_LOG-1:0] releasedPhyMap3_i,

  input  logic                commitDestValid0_i,
  input  logic                commitDestValid1_i,
  input  logic                commitDestValid2_i,
  input  logic                commitDestValid3_i,

  input  logic                recoverFlag_i,
  output logic [PHYS_LOG-1:0] freeCnt_o,
  output logic                overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;

  typedef logic [PTR_W-1:0]    ptr_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [PHYS_LOG-1:0] tag_t;

  localparam logic [PTR_W:0] DEPTH_PTR = (PTR_W + 1)'(DEPTH);

  // Modulo-DEPTH advance; DEPTH need not be a power of two, so wrap explicitly.
  function automatic ptr_t ptrAdd(input ptr_t ptr, input logic [2:0] n);
    logic [PTR_W:0] sum;
    sum = {1'b0, ptr} + (PTR_W + 1)'(n);
    if (sum >= DEPTH_PTR) sum = sum - DEPTH_PTR;
    return sum[PTR_W-1:0];
  endfunction

  function automatic logic [2:0] popCnt4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  tag_t entries [DEPTH];
  ptr_t specHead, archHead, tail;
  cnt_t specCnt, archCnt;

  logic [3:0] relValid;
  logic [3:0] cmtValid;
  tag_t       relTag [4];

  assign relValid  = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
  assign cmtValid  = {commitDestValid3_i, commitDestValid2_i, commitDestValid1_i, commitDestValid0_i};
  assign relTag[0] = releasedPhyMap0_i;
  assign relTag[1] = releasedPhyMap1_i;
  assign relTag[2] = releasedPhyMap2_i;
  assign relTag[3] = releasedPhyMap3_i;

  // Each valid lane lands at tail plus the number of valid older lanes.
  logic [2:0] laneOff [4];
  assign laneOff[0] = 3'd0;
  assign laneOff[1] = popCnt4({3'b0, relValid[0]});
  assign laneOff[2] = popCnt4({2'b0, relValid[1:0]});
  assign laneOff[3] = popCnt4({1'b0, relValid[2:0]});

  logic [2:0] pushCnt, commitCnt, grantCnt;
  logic       grant;

  assign pushCnt   = popCnt4(relValid);
  assign commitCnt = popCnt4(cmtValid);
  assign stall_o   = (specCnt < cnt_t'(4));
  assign grant     = allocReq_i & ~stall_o & ~recoverFlag_i;
  assign grantCnt  = grant ? allocCnt_i : 3'd0;

  logic [SUM_W-1:0] archPlus, archLimit, specSum;
  logic             overflowHit;
  cnt_t             archCntNext, specCntNext;
  ptr_t             archHeadNext, specHeadNext;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    archPlus     = SUM_W'(archCnt) + SUM_W'(pushCnt);
    archLimit    = SUM_W'(DEPTH) + SUM_W'(commitCnt);
    overflowHit  = (archPlus > archLimit);
    archCntNext  = cnt_t'(archPlus - SUM_W'(commitCnt));
    if (overflowHit) archCntNext = cnt_t'(DEPTH);

    specSum      = SUM_W'(specCnt) + SUM_W'(pushCnt) - SUM_W'(grantCnt);
    specCntNext  = cnt_t'(specSum);
    if (specSum > SUM_W'(DEPTH)) specCntNext = cnt_t'(DEPTH);

    archHeadNext = ptrAdd(archHead, commitCnt);
    specHeadNext = ptrAdd(specHead, grantCnt);

    // Recovery discards all speculative allocation, including this cycle's.
    if (recoverFlag_i) begin
      specHeadNext = archHeadNext;
      specCntNext  = archCntNext;
    end
  end

  // NOTE: the storage array is reset because the initial free tags are defined
  // contents, not don't-cares; sequential state always uses non-blocking writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= tag_t'(LOG_REGS + i);
      specHead   <= '0;
      archHead   <= '0;
      tail       <= '0;
      specCnt    <= cnt_t'(DEPTH);
      archCnt    <= cnt_t'(DEPTH);
      overflow_o <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (relValid[k]) entries[ptrAdd(tail, laneOff[k])] <= relTag[k];
      end
      tail       <= ptrAdd(tail, pushCnt);
      archHead   <= archHeadNext;
      specHead   <= specHeadNext;
      archCnt    <= archCntNext;
      specCnt    <= specCntNext;
      overflow_o <= overflow_o | overflowHit;
    end
  end

  assign freeReg0_o = entries[specHead];
  assign freeReg1_o = entries[ptrAdd(specHead, 3'd1)];
  assign freeReg2_o = entries[ptrAdd(specHead, 3'd2)];
  assign freeReg3_o = entries[ptrAdd(specHead, 3'd3)];
  assign freeCnt_o  = PHYS_LOG'(specCnt);

endmodule

// File: tb/tb_spec_free_list.sv
// Bench for spec_free_list: queue-based model of the speculative and
// architectural free lists, per-cycle compare, plus hand-computed anchors.
module tb_spec_free_list;

  localparam int DEPTH    = 62;
  localparam int LOG_REGS = 34;

  logic       clk;
  logic       reset;
  logic       allocReq;
  logic [2:0] allocCnt;
  logic [3:0] relValid;
  logic [3:0] cmtValid;
  logic [6:0] relTag [4];
  logic       recover;

  logic [6:0] freeReg [4];
  logic       stall;
  logic [6:0] freeCnt;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 0;

  // Model: ordered lists of free tags as seen from each head.
  int specQ[$];
  int archQ[$];
  bit mOvf;
  int mCommit;
  bit mGrant;

  spec_free_list dut (
    .clk                (clk),
    .reset              (reset),
    .allocReq_i         (allocReq),
    .allocCnt_i         (allocCnt),
    .freeReg0_o         (freeReg[0]),
    .freeReg1_o         (freeReg[1]),
    .freeReg2_o         (freeReg[2]),
    .freeReg3_o         (freeReg[3]),
    .stall_o            (stall),
    .releasedValid0_i   (relValid[0]),
    .releasedValid1_i   (relValid[1]),
    .releasedValid2_i   (relValid[2]),
    .releasedValid3_i   (relValid[3]),
    .releasedPhyMap0_i  (relTag[0]),
    .releasedPhyMap1_i  (relTag[1]),
    .releasedPhyMap2_i  (relTag[2]),
    .releasedPhyMap3_i  (relTag[3]),
    .commitDestValid0_i (cmtValid[0]),
    .commitDestValid1_i (cmtValid[1]),
    .commitDestValid2_i (cmtValid[2]),
    .commitDestValid3_i (cmtValid[3]),
    .recoverFlag_i      (recover),
    .freeCnt_o          (freeCnt),
    .overflow_o         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      specQ.delete();
      archQ.delete();
      for (int i = 0; i < DEPTH; i++) begin
        specQ.push_back(LOG_REGS + i);
        archQ.push_back(LOG_REGS + i);
      end
      mOvf = 1'b0;
    end else begin
      mGrant = allocReq && (specQ.size() >= 4) && !recover;
      if (mGrant) begin
        for (int n = 0; n < int'(allocCnt); n++)
          if (specQ.size() > 0) void'(specQ.pop_front());
      end
      mCommit = 0;
      for (int k = 0; k < 4; k++) if (cmtValid[k]) mCommit++;
      for (int n = 0; n < mCommit; n++)
        if (archQ.size() > 0) void'(archQ.pop_front());
      for (int k = 0; k < 4; k++) begin
        if (relValid[k]) begin
          specQ.push_back(int'(relTag[k]));
          archQ.push_back(int'(relTag[k]));
        end
      end
      if (archQ.size() > DEPTH) begin
        mOvf = 1'b1;
        while (archQ.size() > DEPTH) void'(archQ.pop_front());
      end
      if (recover) specQ = archQ;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      check("freeCnt", int'(freeCnt), specQ.size());
      check("stall", int'(stall), (specQ.size() < 4) ? 1 : 0);
      check("overflow", int'(overflow), int'(mOvf));
      for (int k = 0; k < 4; k++)
        if (k < specQ.size())
          check($sformatf("freeReg%0d", k), int'(freeReg[k]), specQ[k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    allocReq = 1'b0;
    allocCnt = 3'd0;
    relValid = 4'b0;
    cmtValid = 4'b0;
    recover  = 1'b0;
    for (int k = 0; k < 4; k++) relTag[k] = 7'd0;
  endtask

  task automatic doReset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s freeReg%0d", tag, k), int'(freeReg[k]), 34 + k);
    check({tag, " freeCnt"}, int'(freeCnt), 62);
    check({tag, " stall"}, int'(stall), 0);
    check({tag, " overflow"}, int'(overflow), 0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkEn = 1'b1;
    checkResetState("reset");

    // Drain to stall, then a stalled request must not move the head.
    allocReq = 1'b1;
    allocCnt = 3'd4;
    repeat (15) tick();
    check("drain freeCnt", int'(freeCnt), 2);
    check("drain stall", int'(stall), 1);
    check("drain freeReg0", int'(freeReg[0]), 94);
    allocCnt = 3'd2;
    tick();
    check("stalled freeReg0", int'(freeReg[0]), 94);
    check("stalled freeCnt", int'(freeCnt), 2);
    idle();

    // Sparse release: lanes 0 and 2 only, junk on the invalid lanes.
    relValid  = 4'b0101;
    relTag[0] = 7'd5;
    relTag[1] = 7'd77;
    relTag[2] = 7'd9;
    relTag[3] = 7'd78;
    tick();
    idle();
    check("sparse freeCnt", int'(freeCnt), 4);
    check("sparse freeReg0", int'(freeReg[0]), 94);
    check("sparse freeReg2", int'(freeReg[2]), 5);
    check("sparse freeReg3", int'(freeReg[3]), 9);
    check("sparse stall", int'(stall), 0);
    check("sparse overflow", int'(overflow), 1);

    // Wrap-around with balanced alloc/commit/release.
    doReset();
    checkResetState("post-overflow reset");
    for (int i = 0; i < 20; i++) begin
      allocReq = 1'b1;
      allocCnt = 3'd4;
      cmtValid = 4'b1111;
      relValid = 4'b1111;
      for (int k = 0; k < 4; k++) relTag[k] = 7'(i * 4 + k);
      tick();
    end
    idle();
    check("wrap freeReg0", int'(freeReg[0]), 18);
    check("wrap freeReg1", int'(freeReg[1]), 19);
    check("wrap freeCnt", int'(freeCnt), 62);
    check("wrap overflow", int'(overflow), 0);

    // Recovery with a persistent request: no grants while recovering.
    doReset();
    allocReq = 1'b1;
    allocCnt = 3'd4;
    tick();
    tick();
    check("pre-recover freeCnt", int'(freeCnt), 54);
    check("pre-recover freeReg0", int'(freeReg[0]), 42);
    recover = 1'b1;
    tick();
    check("recover1 freeReg0", int'(freeReg[0]), 34);
    check("recover1 freeCnt", int'(freeCnt), 62);
    tick();
    tick();
    idle();
    tick();
    check("post-recover freeReg0", int'(freeReg[0]), 34);
    check("post-recover freeCnt", int'(freeCnt), 62);

    // Recovery in the same cycle as commit and release of two.
    doReset();
    allocReq = 1'b1;
    allocCnt = 3'd4;
    tick();
    tick();
    allocReq  = 1'b0;
    recover   = 1'b1;
    cmtValid  = 4'b0011;
    relValid  = 4'b0011;
    relTag[0] = 7'd10;
    relTag[1] = 7'd11;
    tick();
    idle();
    check("recover+commit freeReg0", int'(freeReg[0]), 36);
    check("recover+commit freeReg1", int'(freeReg[1]), 37);
    check("recover+commit freeCnt", int'(freeCnt), 62);
    allocReq = 1'b1;
    allocCnt = 3'd4;
    tick();
    check("post-recover alloc freeReg0", int'(freeReg[0]), 40);

    // Reset mid-operation with every other input active.
    reset    = 1'b1;
    recover  = 1'b1;
    relValid = 4'b1111;
    cmtValid = 4'b1111;
    tick();
    checkResetState("reset mid");
    reset = 1'b0;
    idle();
    tick();
    checkResetState("after reset mid");

    // Mixed allocation sizes, with balanced commit/release on the last one.
    allocReq = 1'b1;
    allocCnt = 3'd1;
    tick();
    check("alloc1 freeReg0", int'(freeReg[0]), 35);
    allocCnt = 3'd2;
    tick();
    check("alloc2 freeReg0", int'(freeReg[0]), 37);
    allocCnt  = 3'd3;
    cmtValid  = 4'b0111;
    relValid  = 4'b1110;
    relTag[1] = 7'd1;
    relTag[2] = 7'd2;
    relTag[3] = 7'd3;
    tick();
    cmtValid = 4'b0;
    relValid = 4'b0;
    check("alloc3 freeReg0", int'(freeReg[0]), 40);
    check("alloc3 freeCnt", int'(freeCnt), 59);
    allocCnt = 3'd0;
    tick();
    idle();
    check("alloc0 freeReg0", int'(freeReg[0]), 40);
    check("alloc0 overflow", int'(overflow), 0);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spec_free_list.md
# spec_free_list

Speculative physical-register free list for the rename stage. Up to four previously-mapped physical registers are released per cycle by the architectural map table at commit and pushed into a circular buffer. Rename pops up to four free registers per cycle from the same buffer. Two head pointers are kept: a speculative head advanced by rename allocation, and an architectural head advanced by commit. On branch-mispredict or exception recovery, the speculative head snaps back to the architectural head, which re-frees every register allocated to squashed instructions.

## Interface
Parameters:
- `PHYS_REGS`, 96, physical register file size.
- `LOG_REGS`, 34, logical registers (architectural map table entries).
- `PHYS_LOG`, 7, physical register tag width.
- `DEPTH`, `PHYS_REGS-LOG_REGS` (62), free list entries. Not required to be a power of two.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `allocReq_i`  in  1  rename requests registers this cycle.
- `allocCnt_i`  in  3  number of registers consumed, 0..4.
- `freeReg0_o`..`freeReg3_o`  out  PHYS_LOG each  tags at spec head+0..+3.
- `stall_o`  out  1  fewer than 4 speculative free entries.
- `releasedValid0_i`..`releasedValid3_i`  in  1 each  released tag valid, in program order.
- `releasedPhyMap0_i`..`releasedPhyMap3_i`  in  PHYS_LOG each  released tags.
- `commitDestValid0_i`..`commitDestValid3_i`  in  1 each  committing instruction has a destination.
- `recoverFlag_i`  in  1  recovery in progress; may stay high for multiple cycles.
- `freeCnt_o`  out  PHYS_LOG  speculative free count.
- `overflow_o`  out  1  sticky error flag.

## Operation
- **Storage:** DEPTH x PHYS_LOG register array.
- **Pointers:** `specHead`, `archHead` and `tail`, each ceil(log2 DEPTH) bits. Advancing a pointer by n is addition modulo DEPTH, with an explicit wrap from DEPTH-1 to 0 (not a binary rollover).
- **Counters:** `specCnt` and `archCnt` are free counts from the respective head to `tail`, range 0..DEPTH.
- **Reset state:**
  - entry i = LOG_REGS+i.
  - all pointers = 0.
  - `specCnt` = `archCnt` = DEPTH.
  - `overflow_o` = 0.
- **Read:** `freeRegK_o` = `entry[(specHead+K) mod DEPTH]`, combinational from registered state.
- **Stall:** `stall_o` = (`specCnt` < 4).
- **Grant:** grant = `allocReq_i` & ~`stall_o` & ~`recoverFlag_i`.
  - On grant, `specHead` += `allocCnt_i`.
  - Otherwise no pop; the request is dropped, and the requester re-presents it.
- **Push:**
  - pushCnt = popcount(`releasedValid*`).
  - Valid tags are compacted in lane order (lane 0 oldest) and written at `tail`, `tail`+1, ... mod DEPTH.
  - `tail` += pushCnt.
  - Invalid lanes create no holes.
- **Commit:** `archHead` += popcount(`commitDestValid*`).
- **Count update:**
  - `archCnt_next` = `archCnt` - commitCnt + pushCnt.
  - `specCnt_next` = `specCnt` - grantCnt + pushCnt.
- **Recovery:** while `recoverFlag_i` = 1, `specHead_next` = `archHead_next` and `specCnt_next` = `archCnt_next`. Commits and pushes in the same cycle are still applied.
- **Invariant:** each commit with a destination releases exactly one tag, so `archCnt` stays at DEPTH.
- **Overflow:** if `archCnt` - commitCnt + pushCnt > DEPTH, set `overflow_o` (sticky until reset). The pushes are still performed.

## Timing
- **Grant latency:** an allocation granted in cycle t moves `freeReg*_o` to the next tags in cycle t+1.
- **Push latency:** a tag released in cycle t is readable at `freeReg*_o` no earlier than t+1.
- **Recovery:** the first cycle after `recoverFlag_i` is sampled high shows `freeReg0_o` = `entry[archHead]` and `stall_o` recomputed.
- **Reset mid-operation:** all state returns to the reset state in the next cycle, regardless of other inputs.
- **Same-cycle alloc and release:** simultaneous alloc and release in one cycle is legal. Stall is decided on the pre-update `specCnt`; a same-cycle push does not lift the stall.
- **Other outputs:** `freeCnt_o` = `specCnt`; `overflow_o` is registered.

## Test plan
1. **Reset:** `freeReg0..3_o` = 34,35,36,37; `freeCnt_o` = 62; `stall_o` = 0; `overflow_o` = 0.
2. **Drain to stall:** allocate 4 per cycle for 15 cycles with no release.
   - `freeCnt_o` = 2 and `stall_o` = 1.
   - `freeReg0_o` = 94.
   - A further request with `allocCnt_i`=2 leaves the head unchanged.
3. **Sparse release:** `releasedValid` = 1,0,1,0 with tags 5,x,9,x.
   - The next two tail slots hold 5 then 9.
   - `freeCnt_o` increases by exactly 2.
4. **Wrap-around:**
   - Allocate and commit 4 per cycle, releasing 4 per cycle, for 20 cycles.
   - Pointers wrap 61->0 with no lost tags.
   - `freeReg*_o` sequence continues 34..95, then the released tags in push order.
   - `freeCnt_o` stays 62.
5. **Recovery:**
   - After reset, allocate 8 with no commits (`freeCnt_o` = 54), then hold `recoverFlag_i` high for 3 cycles with `allocReq_i`=1.
   - Next cycle: `freeReg0_o` = 34 and `freeCnt_o` = 62.
   - No grants occur during recovery.
6. **Recovery with commit and reset:**
   - Allocate 8, then assert recovery in the same cycle as commit and release of 2. After recovery, `freeReg0_o` = 36.
   - Asserting reset mid-sequence restores the scenario 1 values.
